// File: rtl/mdu_sched.sv
// HI/LO scheduler for a multiply/divide unit: accepts MULT/DIV requests, launches the
// multicycle unit, commits its result to HI/LO, and trips a sticky watchdog if it hangs.
module mdu_sched #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             mc_start,
    output logic [1:0]       mc_type,
    output logic [WIDTH-1:0] mc_a,
    output logic [WIDTH-1:0] mc_b,
    input  logic             mc_ok,
    input  logic [WIDTH-1:0] mc_hi,
    input  logic [WIDTH-1:0] mc_lo,
    output logic             wd_err
);

    localparam int unsigned      CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StWrite} state_e;

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_hi, w_hi_d;
    logic [WIDTH-1:0] r_lo, w_lo_d;
    logic [WIDTH-1:0] r_res_hi, w_res_hi_d;
    logic [WIDTH-1:0] r_res_lo, w_res_lo_d;
    logic [WIDTH-1:0] r_a, w_a_d;
    logic [WIDTH-1:0] r_b, w_b_d;
    logic [1:0]       r_type, w_type_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_wd, w_wd_d;

    logic             w_md_op;
    logic             w_div0;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_stall;
    logic             w_start;
    logic             w_done;

    assign w_md_op   = ~req_op[2];
    assign w_div0    = (req_op == 3'd2 || req_op == 3'd3) && (req_b == '0);
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_hi     <= '0;
            r_lo     <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_type   <= '0;
            r_cnt    <= '0;
            r_wd     <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_hi     <= w_hi_d;
            r_lo     <= w_lo_d;
            r_res_hi <= w_res_hi_d;
            r_res_lo <= w_res_lo_d;
            r_a      <= w_a_d;
            r_b      <= w_b_d;
            r_type   <= w_type_d;
            r_cnt    <= w_cnt_d;
            r_wd     <= w_wd_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_hi_d     = r_hi;
        w_lo_d     = r_lo;
        w_res_hi_d = r_res_hi;
        w_res_lo_d = r_res_lo;
        w_a_d      = r_a;
        w_b_d      = r_b;
        w_type_d   = r_type;
        w_cnt_d    = r_cnt;
        w_wd_d     = r_wd;
        w_stall    = 1'b0;
        w_start    = 1'b0;
        w_done     = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_stall = req_valid & w_md_op & ~w_div0;
                if (req_valid && !flush) begin
                    if (w_md_op && !w_div0) begin
                        w_state_d = StIssue;
                        w_type_d  = req_op[1:0];
                        w_a_d     = req_a;
                        w_b_d     = req_b;
                    end else if (req_op == 3'd4) begin
                        w_hi_d = req_a;
                    end else if (req_op == 3'd5) begin
                        w_lo_d = req_a;
                    end
                end
            end
            StIssue: begin
                w_stall   = req_valid;
                w_start   = 1'b1;
                w_cnt_d   = '0;
                w_state_d = StWait;
            end
            StWait: begin
                w_stall = req_valid;
                w_cnt_d = w_cnt_inc;
                if (mc_ok) begin
                    w_res_hi_d = mc_hi;
                    w_res_lo_d = mc_lo;
                    w_state_d  = StWrite;
                end else if (w_cnt_inc == CNT_MAX) begin
                    w_wd_d    = 1'b1;
                    w_state_d = StIdle;
                end
            end
            StWrite: begin
                // The retiring request is released in the commit cycle.
                w_done    = 1'b1;
                w_hi_d    = r_res_hi;
                w_lo_d    = r_res_lo;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase

        if (flush) begin
            w_state_d = StIdle;
            w_start   = 1'b0;
            w_done    = 1'b0;
            w_hi_d    = r_hi;
            w_lo_d    = r_lo;
            w_wd_d    = r_wd;
        end
    end

    assign stall    = w_stall & ~reset;
    assign done     = w_done;
    assign mc_start = w_start;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign mc_type  = r_type;
    assign mc_a     = r_a;
    assign mc_b     = r_b;
    assign wd_err   = r_wd;

endmodule

// File: tb/tb_mdu_sched.sv
// Bench for mdu_sched: two instances (TIMEOUT 64 and 8) against a transaction-level model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mdu_sched;

    localparam int W = 32;

    logic         clk       = 1'b0;
    logic         reset     = 1'b0;
    logic         flush     = 1'b0;
    logic         req_valid = 1'b0;
    logic [2:0]   req_op    = '0;
    logic [W-1:0] req_a     = '0;
    logic [W-1:0] req_b     = '0;
    logic         mc_ok     = 1'b0;
    logic [W-1:0] mc_hi     = '0;
    logic [W-1:0] mc_lo     = '0;

    logic         stall_o [2];
    logic         done_o  [2];
    logic         start_o [2];
    logic         wd_o    [2];
    logic [1:0]   type_o  [2];
    logic [W-1:0] hi_o    [2];
    logic [W-1:0] lo_o    [2];
    logic [W-1:0] mca_o   [2];
    logic [W-1:0] mcb_o   [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mdu_sched #(.WIDTH(W), .TIMEOUT(64)) u_dut_a (
        .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .stall(stall_o[0]), .hi(hi_o[0]), .lo(lo_o[0]),
        .done(done_o[0]), .mc_start(start_o[0]), .mc_type(type_o[0]), .mc_a(mca_o[0]),
        .mc_b(mcb_o[0]), .mc_ok(mc_ok), .mc_hi(mc_hi), .mc_lo(mc_lo), .wd_err(wd_o[0])
    );

    mdu_sched #(.WIDTH(W), .TIMEOUT(8)) u_dut_b (
        .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .stall(stall_o[1]), .hi(hi_o[1]), .lo(lo_o[1]),
        .done(done_o[1]), .mc_start(start_o[1]), .mc_type(type_o[1]), .mc_a(mca_o[1]),
        .mc_b(mcb_o[1]), .mc_ok(mc_ok), .mc_hi(mc_hi), .mc_lo(mc_lo), .wd_err(wd_o[1])
    );

    // Transaction model: a request is either absent, waiting to be launched, launched and
    // waiting for a result, or holding a result to commit.
    int           tmo        [2] = '{64, 8};
    logic         m_busy     [2];
    logic         m_launched [2];
    logic         m_ready    [2];
    logic         m_wd       [2];
    int           m_waited   [2];
    logic [W-1:0] m_hi [2], m_lo [2], m_rhi [2], m_rlo [2], m_a [2], m_b [2];
    logic [1:0]   m_type [2];

    function automatic logic launchable(input logic [2:0] op, input logic [W-1:0] b);
        return (op < 3'd4) && !(op >= 3'd2 && b == 0);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_busy[i] <= 1'b0; m_launched[i] <= 1'b0; m_ready[i] <= 1'b0;
                m_wd[i] <= 1'b0; m_waited[i] <= 0;
                m_hi[i] <= '0; m_lo[i] <= '0; m_rhi[i] <= '0; m_rlo[i] <= '0;
                m_a[i] <= '0; m_b[i] <= '0; m_type[i] <= '0;
            end else if (flush) begin
                m_busy[i] <= 1'b0;
            end else if (!m_busy[i]) begin
                if (req_valid && launchable(req_op, req_b)) begin
                    m_busy[i] <= 1'b1; m_launched[i] <= 1'b0; m_ready[i] <= 1'b0;
                    m_type[i] <= req_op[1:0]; m_a[i] <= req_a; m_b[i] <= req_b;
                end else if (req_valid && req_op == 3'd4) begin
                    m_hi[i] <= req_a;
                end else if (req_valid && req_op == 3'd5) begin
                    m_lo[i] <= req_a;
                end
            end else if (m_ready[i]) begin
                m_hi[i] <= m_rhi[i]; m_lo[i] <= m_rlo[i]; m_busy[i] <= 1'b0;
            end else if (!m_launched[i]) begin
                m_launched[i] <= 1'b1; m_waited[i] <= 0;
            end else begin
                m_waited[i] <= m_waited[i] + 1;
                if (mc_ok) begin
                    m_ready[i] <= 1'b1; m_rhi[i] <= mc_hi; m_rlo[i] <= mc_lo;
                end else if (m_waited[i] + 1 >= tmo[i]) begin
                    m_wd[i] <= 1'b1; m_busy[i] <= 1'b0;
                end
            end
        end
    end

    logic  e_stall, e_start, e_done;
    string pfx;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            pfx     = (i == 0) ? "A." : "B.";
            e_stall = !reset && req_valid &&
                      (m_busy[i] ? !m_ready[i] : launchable(req_op, req_b));
            e_start = !reset && m_busy[i] && !m_launched[i] && !flush;
            e_done  = !reset && m_busy[i] && m_ready[i] && !flush;
            check({pfx, "stall"},   W'(stall_o[i]), W'(e_stall));
            check({pfx, "mc_start"}, W'(start_o[i]), W'(e_start));
            check({pfx, "done"},    W'(done_o[i]),  W'(e_done));
            check({pfx, "hi"},      hi_o[i],        m_hi[i]);
            check({pfx, "lo"},      lo_o[i],        m_lo[i]);
            check({pfx, "mc_type"}, W'(type_o[i]),  W'(m_type[i]));
            check({pfx, "mc_a"},    mca_o[i],       m_a[i]);
            check({pfx, "mc_b"},    mcb_o[i],       m_b[i]);
            check({pfx, "wd_err"},  W'(wd_o[i]),    W'(m_wd[i]));
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        req_valid = v; req_op = op; req_a = a; req_b = b;
    endtask

    int bad_stall, bad_start, bad_done;

    initial begin
        #2 reset = 1'b1;
        drive(1'b1, 3'd0, 32'd9, 32'd2);
        mid();
        check("reset stall", W'(stall_o[0]), 0);
        check("reset hi", hi_o[0], 0);
        check("reset lo", lo_o[0], 0);
        check("reset mc_a", mca_o[0], 0);
        check("reset wd_err", W'(wd_o[0]), 0);

        // Divide by zero is dropped without launching.
        cyc(); reset = 1'b0;
        drive(1'b1, 3'd3, 32'd7, 32'd0);
        mid(); check("divu0 stall", W'(stall_o[0]), 0);
        cyc(); mid();
        check("divu0 mc_start", W'(start_o[0]), 0);
        check("divu0 done", W'(done_o[0]), 0);
        check("divu0 hi", hi_o[0], 0);

        // MTHI in IDLE.
        cyc(); drive(1'b1, 3'd4, 32'h1234, 32'd0);
        mid(); check("mthi stall", W'(stall_o[0]), 0);
        cyc(); drive(1'b0, 3'd0, 32'd0, 32'd0);
        mid(); check("mthi hi", hi_o[0], 32'h1234);

        // MULT with the result arriving in WAIT cycle 33; B times out after 8.
        cyc(); drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd2);
        mid(); check("mult accept stall", W'(stall_o[0]), 1);
        cyc(); mid();
        check("mult mc_start", W'(start_o[0]), 1);
        check("mult mc_a", mca_o[0], 32'hFFFF_FFFF);
        check("mult mc_b", mcb_o[0], 32'd2);
        bad_stall = 0; bad_start = 0; bad_done = 0;
        for (int k = 1; k <= 33; k++) begin
            cyc();
            mc_ok = (k == 33);
            mc_hi = (k == 33) ? 32'hFFFF_FFFF : $urandom;
            mc_lo = (k == 33) ? 32'hFFFF_FFFE : $urandom;
            if (k == 10) drive(1'b1, 3'd5, 32'hBEEF, 32'd2);
            else drive(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd2);
            mid();
            if (stall_o[0] !== 1'b1) bad_stall++;
            if (start_o[0] !== 1'b0) bad_start++;
            if (done_o[0] !== 1'b0) bad_done++;
            if (k == 8) check("B wd before timeout", W'(wd_o[1]), 0);
            if (k == 9) check("B wd after timeout", W'(wd_o[1]), 1);
            if (k == 10) check("B relaunch after timeout", W'(start_o[1]), 1);
            if (k == 10) check("mtlo busy stall", W'(stall_o[0]), 1);
            if (k == 11) check("mtlo busy lo", lo_o[0], 0);
        end
        check("wait stall low count", bad_stall, 0);
        check("wait extra mc_start", bad_start, 0);
        check("wait early done", bad_done, 0);
        cyc(); mc_ok = 1'b0;
        mid();
        check("mult done", W'(done_o[0]), 1);
        check("mult done stall", W'(stall_o[0]), 0);
        check("mult hi before commit", hi_o[0], 32'h1234);
        cyc(); drive(1'b0, 3'd0, 32'd0, 32'd0);
        mid();
        check("mult hi", hi_o[0], 32'hFFFF_FFFF);
        check("mult lo", lo_o[0], 32'hFFFF_FFFE);

        // DIV flushed in its 5th WAIT cycle; a late mc_ok must not commit.
        cyc(); drive(1'b1, 3'd2, 32'd100, 32'd7);
        cyc();
        for (int k = 1; k <= 5; k++) begin
            cyc(); flush = (k == 5);
        end
        mid();
        check("flush done", W'(done_o[0]), 0);
        cyc(); flush = 1'b0; drive(1'b0, 3'd0, 32'd0, 32'd0);
        cyc(); mc_ok = 1'b1; mc_hi = 32'h5555; mc_lo = 32'h6666;
        mid();
        check("flush late done", W'(done_o[0]), 0);
        check("flush hi", hi_o[0], 32'hFFFF_FFFF);
        check("flush lo", lo_o[0], 32'hFFFF_FFFE);

        // MULTU at minimum latency; mc_ok before WAIT must be ignored.
        cyc(); drive(1'b1, 3'd1, 32'd3, 32'd5); mc_hi = 32'hDEAD; mc_lo = 32'hBEEF;
        mid(); check("multu accept stall", W'(stall_o[0]), 1);
        cyc(); mc_hi = 32'h1111; mc_lo = 32'h1111;
        mid(); check("multu mc_type", W'(type_o[0]), 1);
        cyc(); mc_hi = 32'd0; mc_lo = 32'd15;
        mid(); check("multu wait done", W'(done_o[0]), 0);
        cyc(); mc_hi = 32'h2222; mc_lo = 32'h2222;
        mid(); check("multu done", W'(done_o[0]), 1);
        cyc(); mc_ok = 1'b0; drive(1'b1, 3'd4, 32'hCAFE, 32'd0);
        mid();
        check("multu hi", hi_o[0], 32'd0);
        check("multu lo", lo_o[0], 32'd15);

        // Asynchronous reset while in WAIT.
        cyc(); drive(1'b1, 3'd0, 32'd5, 32'd6);
        mid(); check("pre-reset hi", hi_o[0], 32'hCAFE);
        cyc(); cyc(); cyc(); cyc();
        #2 reset = 1'b1;
        #1;
        check("async reset hi", hi_o[0], 0);
        check("async reset lo", lo_o[0], 0);
        check("async reset stall", W'(stall_o[0]), 0);
        check("async reset B wd", W'(wd_o[1]), 0);
        mid(); reset = 1'b0;
        #1 check("post-reset stall", W'(stall_o[0]), 1);

        for (int c = 0; c < 3000; c++) begin
            cyc();
            req_valid = $urandom_range(0, 9) < 7;
            req_op    = 3'($urandom_range(0, 7));
            req_a     = $urandom;
            req_b     = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            flush     = $urandom_range(0, 39) == 0;
            mc_ok     = (c % 700 < 120) ? 1'b0 : ($urandom_range(0, 5) == 0);
            mc_hi     = $urandom;
            mc_lo     = $urandom;
        end
        mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
